// File: rtl/add_accumulator.sv
// Batches N_OPS 5-bit terms (A+B+Cin) into an ACC_W accumulator; acc/ovf/op_cnt update on the accepting edge.
// Result held in DONE until out_ready; define ADD_ACCUMULATOR_SAT_EN to saturate instead of wrap on overflow.
module add_accumulator #(
    parameter int N_OPS = 4,
    parameter int ACC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             ovf,
    output logic [3:0]       op_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DONE = 1'b1
    } state_t;

    localparam logic [3:0] LP_LAST = 4'(N_OPS - 1);

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [3:0]       r_op_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [4:0]       w_term;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_last;

    assign w_term  = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
    assign w_sum   = {1'b0, r_acc} + {{(ACC_W-4){1'b0}}, w_term};
    assign w_carry = w_sum[ACC_W];
    assign w_last  = (r_op_cnt == LP_LAST);

`ifdef ADD_ACCUMULATOR_SAT_EN
    // Once overflowed, the batch stays pinned at full scale until it is zeroed.
    assign w_acc_next = (w_carry || r_ovf) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_op_cnt    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_op_cnt    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= w_acc_next;
                        r_ovf    <= r_ovf | w_carry;
                        r_op_cnt <= r_op_cnt + 4'd1;
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Hand-off zeroes the batch so IDLE can accept on the very next edge.
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_op_cnt    <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign acc       = r_acc;
    assign ovf       = r_ovf;
    assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_add_accumulator.sv
// Directed table-driven bench for add_accumulator (default N_OPS=4, ACC_W=6).
module tb_add_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic       Cin;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] acc;
    logic       ovf;
    logic [3:0] op_cnt;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    add_accumulator #(.N_OPS(4), .ACC_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .ovf       (ovf),
        .op_cnt    (op_cnt)
    );

    typedef struct {
        int clr;
        int vld;
        int a;
        int b;
        int cin;
        int ordy;
        int e_acc;
        int e_ovf;
        int e_cnt;
        int e_irdy;
        int e_ovld;
    } vec_t;

`ifdef ADD_ACCUMULATOR_SAT_EN
    localparam int OV3 = 63;
    localparam int OV4 = 63;
`else
    localparam int OV3 = 19;
    localparam int OV4 = 50;
`endif

    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int e_acc, input int e_ovf, input int e_cnt,
                           input int e_irdy, input int e_ovld);
        chk({tag, " acc"}, int'(acc), e_acc);
        chk({tag, " ovf"}, int'(ovf), e_ovf);
        chk({tag, " op_cnt"}, int'(op_cnt), e_cnt);
        chk({tag, " in_ready"}, int'(in_ready), e_irdy);
        chk({tag, " out_valid"}, int'(out_valid), e_ovld);
    endtask

    task automatic add(input int clr, input int vld, input int a, input int b, input int cin,
                       input int ordy, input int e_acc, input int e_ovf, input int e_cnt,
                       input int e_irdy, input int e_ovld);
        vec_t v;
        v.clr = clr; v.vld = vld; v.a = a; v.b = b; v.cin = cin; v.ordy = ordy;
        v.e_acc = e_acc; v.e_ovf = e_ovf; v.e_cnt = e_cnt; v.e_irdy = e_irdy; v.e_ovld = e_ovld;
        vt.push_back(v);
    endtask

    // Drive one cycle's inputs, take the edge, sample 1 time unit later.
    task automatic step(input int clr, input int vld, input int a, input int b, input int cin,
                        input int ordy);
        clear     = clr[0];
        in_valid  = vld[0];
        A         = a[3:0];
        B         = b[3:0];
        Cin       = cin[0];
        out_ready = ordy[0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  clr vld  a   b  cin ordy  acc ovf cnt irdy ovld
        add(0, 1, 14, 14, 1, 0,   29, 0, 1, 1, 0);   // basic sum
        add(0, 1,  9, 13, 1, 0,   52, 0, 2, 1, 0);
        add(0, 1,  1,  1, 0, 0,   54, 0, 3, 1, 0);
        add(0, 1,  0,  0, 0, 0,   54, 0, 4, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 1, 3, 3, 0, 0, 54, 0, 4, 0, 1);  // backpressure, input ignored
        add(0, 1,  3,  3, 0, 1,    0, 0, 0, 1, 0);   // hand-off, pair not taken
        add(0, 1,  3,  3, 0, 0,    6, 0, 1, 1, 0);   // resumes next cycle
        add(0, 0,  0,  0, 0, 1,    6, 0, 1, 1, 0);   // out_ready in IDLE ignored
        add(1, 0,  0,  0, 0, 0,    0, 0, 0, 1, 0);   // clear mid-batch
        add(0, 1, 14, 14, 1, 1,   29, 0, 1, 1, 0);   // overflow batch
        add(0, 1,  9, 13, 1, 0,   52, 0, 2, 1, 0);
        add(0, 1, 15, 15, 1, 0,  OV3, 1, 3, 1, 0);
        add(0, 1, 15, 15, 1, 0,  OV4, 1, 4, 0, 1);
        add(0, 0,  0,  0, 0, 0,  OV4, 1, 4, 0, 1);   // sticky ovf held in DONE
        add(1, 1,  5,  5, 0, 0,    0, 0, 0, 1, 0);   // clear discards pending result
        add(0, 1, 14, 14, 1, 0,   29, 0, 1, 1, 0);   // clear collision
        add(0, 1,  9, 13, 1, 0,   52, 0, 2, 1, 0);
        add(1, 1, 15, 15, 1, 0,    0, 0, 0, 1, 0);
        add(0, 1,  1,  2, 0, 0,    3, 0, 1, 1, 0);
        add(0, 1,  1,  1, 0, 0,    5, 0, 2, 1, 0);
        add(0, 1,  0,  0, 1, 0,    6, 0, 3, 1, 0);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 1, 0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].clr, vt[i].vld, vt[i].a, vt[i].b, vt[i].cin, vt[i].ordy);
            chk_all($sformatf("vec%0d", i), vt[i].e_acc, vt[i].e_ovf, vt[i].e_cnt,
                    vt[i].e_irdy, vt[i].e_ovld);
        end

        // Async reset between edges after three pairs: must act without a clock edge.
        in_valid = 1'b1; A = 4'd15; B = 4'd15; Cin = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 0, 0, 0, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        step(0, 1, 15, 15, 1, 0);
        chk_all("post_rst1", 31, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0, 0);
        chk_all("post_rst2", 31, 0, 2, 1, 0);
        step(0, 1, 7, 8, 1, 0);
        chk_all("post_rst3", 47, 0, 3, 1, 0);
        step(0, 1, 1, 2, 0, 0);
        chk_all("post_rst4", 50, 0, 4, 0, 1);

        // Reset while a result is pending drops it immediately.
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst_in_done", 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 2, 3, 1, 0);
        chk_all("after_done_rst", 6, 0, 1, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 SHALL have parameter N_OPS, default 4, meaning operand pairs summed per result (legal range 1..15).
REQ-002 SHALL have parameter ACC_W, default 6, meaning accumulator width in bits (legal range 5..16).
REQ-003 SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port clear  input  1  meaning synchronous abort/zero request.
REQ-006 SHALL have port in_valid  input  1  meaning operand pair present.
REQ-007 SHALL have port in_ready  output  1  meaning block can accept an operand pair.
REQ-008 SHALL have ports A, B  input  4 each  meaning operands.
REQ-009 SHALL have port Cin  input  1  meaning carry-in for the pair.
REQ-010 SHALL have port out_valid  output  1  meaning result available.
REQ-011 SHALL have port out_ready  input  1  meaning downstream takes the result.
REQ-012 SHALL have port acc  output  ACC_W  meaning running or final sum.
REQ-013 SHALL have port ovf  output  1  meaning sticky accumulator overflow.
REQ-014 SHALL have port op_cnt  output  4  meaning pairs accepted in the current batch.

Function
REQ-015 SHALL compute each term as the 5-bit value {cout,sum} = A + B + Cin (0..31), zero-extended to ACC_W+1 bits before addition.
REQ-016 SHALL implement states IDLE (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-017 SHALL accept a pair on a rising edge where in_valid=1 and in_ready=1; acc, ovf and op_cnt reflect that pair on the same edge (one-cycle latency, no combinational path from inputs to acc).
REQ-018 SHALL increment op_cnt by 1 per accepted pair; the accept making op_cnt equal N_OPS moves IDLE to DONE.
REQ-019 SHALL hold acc, ovf and op_cnt stable and ignore in_valid while in DONE.
REQ-020 SHALL, in DONE with out_ready=1 at a rising edge, zero acc, ovf and op_cnt and return to IDLE; back-to-back acceptance resumes the following cycle.
REQ-021 SHALL set ovf when the ACC_W+1-bit addition carries out of bit ACC_W-1; ovf stays 1 until clear, rst or result hand-off.
REQ-022 SHALL give clear priority over every other event: on a rising edge with clear=1, acc, ovf and op_cnt go to 0, state goes to IDLE, any simultaneous in_valid pair is dropped and any pending result is discarded.
REQ-023 SHALL treat out_ready while in IDLE as don't-care.

Reset
REQ-024 SHALL, while rst=1, force state to IDLE, acc=0, ovf=0, op_cnt=0, out_valid=0 and in_ready=1, independent of clk.
REQ-025 SHALL, on rst asserted mid-batch or in DONE, abandon the batch with no partial result emitted.
REQ-026 SHALL leave reset cleanly: the first acceptance is possible on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL support macro ADD_ACCUMULATOR_SAT_EN.
REQ-028 SHALL, when ADD_ACCUMULATOR_SAT_EN is defined, clamp acc to 2^ACC_W-1 on overflow and hold it there for the rest of the batch, with ovf=1.
REQ-029 SHALL, when ADD_ACCUMULATOR_SAT_EN is undefined, let acc wrap modulo 2^ACC_W, with ovf=1.

Verification
REQ-030 SHALL cover basic sum: pairs (14,14,1),(9,13,1),(1,1,0),(0,0,0) on consecutive cycles -> acc 29,52,54,54; out_valid=1 after the 4th pair, acc=54, ovf=0, op_cnt=4.
REQ-031 SHALL cover overflow: pairs (14,14,1),(9,13,1),(15,15,1),(15,15,1) -> ovf=1 after the 3rd pair; final acc=50 in wrap build, 63 in ADD_ACCUMULATOR_SAT_EN build.
REQ-032 SHALL cover backpressure: hold out_ready=0 five cycles in DONE while driving in_valid=1 with (3,3,0) -> acc=54 held, op_cnt=4, in_ready=0; then out_ready=1 -> next edge acc=0, IDLE.
REQ-033 SHALL cover clear collision: after two pairs (acc=52), assert clear together with in_valid=1 (15,15,1) -> next edge acc=0, op_cnt=0, ovf=0, pair dropped.
REQ-034 SHALL cover async reset: assert rst between clock edges after three pairs -> acc=0, out_valid=0, in_ready=1 immediately; a new 4-pair batch after release yields the correct total.
